// File: rtl/channel_poll_packer.sv
// Round-robin poller: grants one full channel, drains BURST_LEN words via rdreq
// and frames them as SYNC_WORD, ID, data[...] on a valid/ready 16-bit stream.
// Ports: clk, rst_n (async low), fifo_full/data_in/rdreq per channel,
//        pkt_data/pkt_valid/pkt_ready/pkt_sop/pkt_eop stream, busy.
// Option: define CHECKSUM_EN to append a 16-bit sum word (ID + data) with eop.
module channel_poll_packer #(
    parameter int          CH_NUM    = 4,
    parameter int          BURST_LEN = 256,
    parameter int          RD_LAT    = 2,
    parameter logic [15:0] SYNC_WORD = 16'hEB90,
    parameter int          QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_NUM-1:0]    fifo_full,
    input  logic [16*CH_NUM-1:0] data_in,
    output logic [CH_NUM-1:0]    rdreq,
    output logic [15:0]          pkt_data,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic                 pkt_sop,
    output logic                 pkt_eop,
    output logic                 busy
);

    localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam int IW = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ID,
        DATA,
`ifdef CHECKSUM_EN
        CKS,
`endif
        WAIT
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   rr;
    logic [GW-1:0]   scan;
    logic            scan_hit;
    logic [IW-1:0]   issued;
    logic [IW-1:0]   pushed;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [RD_LAT-1:0] rd_pipe;
    logic [17:0]     mem [QDEPTH];
    logic [17:0]     head;
    logic [17:0]     din;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            issue;
    logic            cap;
    logic            push;
    logic            pop;
    logic            last;
    logic [15:0]     cap_data;
    logic [15:0]     id_word;
`ifdef CHECKSUM_EN
    logic [15:0]     cks;
    logic            full;
    assign full = (count == CW'(QDEPTH));
`endif

    // Lowest offset from rr wins: the loop runs downward so it assigns last.
    always_comb begin
        scan_hit = 1'b0;
        scan     = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (fifo_full[(int'(rr) + i) % CH_NUM]) begin
                scan_hit = 1'b1;
                scan     = GW'((int'(rr) + i) % CH_NUM);
            end
        end
    end

    // Credit: words queued plus reads outstanding never exceed QDEPTH.
    assign issue = (state == DATA) && (issued < IW'(BURST_LEN)) &&
                   (({1'b0, count} + {1'b0, inflight}) < SW'(QDEPTH));
    assign rdreq    = issue ? (CH_NUM'(1) << grant) : '0;
    assign cap      = rd_pipe[RD_LAT-1];
    assign cap_data = data_in[16*grant +: 16];
    assign last     = (pushed == IW'(BURST_LEN - 1));
    assign id_word  = {4'hA, 4'h0, 8'(grant)};

    assign head      = mem[rptr];
    assign pkt_valid = (count != '0);
    assign pkt_data  = pkt_valid ? head[15:0] : 16'h0;
    assign pkt_sop   = pkt_valid & head[17];
    assign pkt_eop   = pkt_valid & head[16];
    assign pop       = pkt_valid & pkt_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt  = state;
        push = 1'b0;
        din  = '0;
        unique case (state)
            IDLE: if (scan_hit) nxt = HDR;
            HDR: begin
                push = 1'b1;
                din  = {2'b10, SYNC_WORD};
                nxt  = ID;
            end
            ID: begin
                push = 1'b1;
                din  = {2'b00, id_word};
                nxt  = DATA;
            end
            DATA: begin
                if (cap) begin
                    push = 1'b1;
`ifdef CHECKSUM_EN
                    din = {2'b00, cap_data};
                    if (last) nxt = CKS;
`else
                    din = {1'b0, last, cap_data};
                    if (last) nxt = WAIT;
`endif
                end
            end
`ifdef CHECKSUM_EN
            CKS: begin
                din = {2'b01, cks};
                if (!full) begin
                    push = 1'b1;
                    nxt  = WAIT;
                end
            end
`endif
            WAIT: if (pop && pkt_eop) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            rr       <= '0;
            issued   <= '0;
            pushed   <= '0;
            inflight <= '0;
            rd_pipe  <= '0;
`ifdef CHECKSUM_EN
            cks      <= '0;
`endif
        end else begin
            if (state == IDLE && scan_hit) grant <= scan;
            if (state == WAIT && nxt == IDLE)
                rr <= (grant == GW'(CH_NUM - 1)) ? '0 : grant + GW'(1);
            if (state == HDR) begin
                issued <= '0;
                pushed <= '0;
            end
            if (issue) issued <= issued + IW'(1);
            if (state == DATA && cap) pushed <= pushed + IW'(1);
            inflight <= inflight + CW'(issue) - CW'(cap);
            rd_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
`ifdef CHECKSUM_EN
            if (state == HDR) cks <= '0;
            if (state == ID) cks <= cks + id_word;
            if (state == DATA && cap) cks <= cks + cap_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_channel_poll_packer.sv
// Scoreboard bench for channel_poll_packer: channel FIFO models with RD_LAT
// read latency, expected packets queued when a channel is armed.
module tb_channel_poll_packer;

    localparam int CH = 4;
    localparam int BL = 8;
    localparam int RL = 2;
    localparam int QD = 4;
`ifdef CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   fifo_full;
    logic [16*CH-1:0] data_in;
    logic [CH-1:0]   rdreq;
    logic [15:0]     pkt_data;
    logic            pkt_valid;
    logic            pkt_ready;
    logic            pkt_sop;
    logic            pkt_eop;
    logic            busy;

    channel_poll_packer #(
        .CH_NUM(CH), .BURST_LEN(BL), .RD_LAT(RL),
        .SYNC_WORD(16'hEB90), .QDEPTH(QD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_full(fifo_full),
        .data_in(data_in), .rdreq(rdreq), .pkt_data(pkt_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] w;
        bit          fd;
        bit          ld;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   t1 = 0;
    bit   slow = 1'b0;

    logic        arm [CH] = '{default: 1'b0};
    int          start [CH] = '{default: 0};
    int          cut [CH] = '{default: 0};
    logic [15:0] base [CH] = '{default: 16'h0};
    int          rd_total [CH] = '{default: 0};
    logic [15:0] p0 [CH] = '{default: 16'h0};
    logic [15:0] p1 [CH] = '{default: 16'h0};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always_comb begin
        fifo_full = '0;
        data_in   = '0;
        for (int c = 0; c < CH; c++) begin
            fifo_full[c] = arm[c] && ((rd_total[c] - start[c]) < cut[c]);
            data_in[16*c +: 16] = p1[c];
        end
    end

    // Channel FIFO read side: k-th read after arming returns base+k.
    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rdreq[c]) begin
                p0[c] <= base[c] + 16'(rd_total[c] - start[c] + 1);
                rd_total[c] <= rd_total[c] + 1;
            end
            p1[c] <= p0[c];
        end
    end

    initial begin
        pkt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            pkt_ready = slow ? (cyc % 3 == 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rdreq != '0) check("onehot", 32'($onehot0(rdreq)), 32'd1);
            if (pkt_valid) begin
                if (sb.size() == 0) begin
                    check("spurious", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb[0];
                    check(pkt_ready ? "word" : "hold",
                          {14'b0, pkt_sop, pkt_eop, pkt_data},
                          {14'b0, mon_e.w});
                    if (pkt_ready) begin
                        if (mon_e.fd) t0 = cyc;
                        if (mon_e.ld) t1 = cyc;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic expect_pkt(int c, logic [15:0] b);
        exp_t        e;
        logic [15:0] s;
        logic [15:0] d;
        e.fd = 1'b0;
        e.ld = 1'b0;
        e.w  = {2'b10, 16'hEB90};
        sb.push_back(e);
        e.w = {2'b00, 8'hA0, 8'(c)};
        sb.push_back(e);
        s = e.w[15:0];
        for (int k = 1; k <= BL; k++) begin
            d    = b + 16'(k);
            e.w  = {1'b0, (k == BL) && !CKS, d};
            e.fd = (k == 1);
            e.ld = (k == BL);
            sb.push_back(e);
            s = s + d;
        end
        if (CKS) begin
            e.fd = 1'b0;
            e.ld = 1'b0;
            e.w  = {2'b01, s};
            sb.push_back(e);
        end
    endtask

    task automatic arm_ch(int c, logic [15:0] b, int ct);
        base[c]  = b;
        start[c] = rd_total[c];
        cut[c]   = ct;
        arm[c]   = 1'b1;
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_out", 32'({rdreq, pkt_data, pkt_valid,
                              pkt_sop, pkt_eop, busy}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_out", 32'({rdreq, pkt_data, pkt_valid,
                              pkt_sop, pkt_eop, busy}), 32'd0);

        expect_pkt(2, 16'h0000);
        arm_ch(2, 16'h0000, BL);
        wait_done("ch2");
        check("ch2_reads", 32'(rd_total[2] - start[2]), 32'(BL));
        check("tput", 32'(t1 - t0), 32'(BL - 1));

        pulse_reset();
        expect_pkt(0, 16'h0100);
        expect_pkt(3, 16'h0300);
        arm_ch(0, 16'h0100, BL);
        arm_ch(3, 16'h0300, BL);
        wait_done("ch0_ch3");
        check("ch0_reads", 32'(rd_total[0] - start[0]), 32'(BL));
        check("ch3_reads", 32'(rd_total[3] - start[3]), 32'(BL));

        expect_pkt(1, 16'h0500);
        expect_pkt(3, 16'h0700);
        arm_ch(1, 16'h0500, BL);
        arm_ch(3, 16'h0700, BL);
        wait_done("ch1_ch3");

        slow = 1'b1;
        expect_pkt(1, 16'h1100);
        arm_ch(1, 16'h1100, BL);
        wait_done("slow");
        check("slow_reads", 32'(rd_total[1] - start[1]), 32'(BL));
        slow = 1'b0;

        expect_pkt(2, 16'h2200);
        arm_ch(2, 16'h2200, 3);
        wait_done("drop");
        check("drop_reads", 32'(rd_total[2] - start[2]), 32'(BL));

        begin
            int n = 0;
            expect_pkt(3, 16'h3300);
            arm_ch(3, 16'h3300, BL);
            while ((rd_total[3] - start[3]) < 4 && n < 500) begin
                @(posedge clk);
                n++;
            end
            check("mid_wait", 32'(n < 500), 32'd1);
            #2;
            arm[3] = 1'b0;
            rst_n  = 1'b0;
            sb.delete();
            #1;
            check("mid_rdreq", 32'(rdreq), 32'd0);
            check("mid_valid", 32'(pkt_valid), 32'd0);
            check("mid_busy", 32'(busy), 32'd0);
            repeat (2) @(posedge clk);
            #2;
            rst_n = 1'b1;
        end
        expect_pkt(1, 16'h4400);
        arm_ch(1, 16'h4400, BL);
        wait_done("post_rst");
        check("post_reads", 32'(rd_total[1] - start[1]), 32'(BL));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
